// File: rtl/approx_add_rr_sched.sv
// Round-robin front end that time-shares one approximate adder among N_REQ requesters.
// The adder sits outside this block, so any approximate variant can be swapped in without touching clients.
//
// state | meaning
// IDLE  | scan req_valid from rr_ptr and grant the first valid requester
// EXEC  | operands held on the adder; count down the settle time, then capture add_o
// RESP  | hold rsp_valid/rsp_id/rsp_sum until rsp_ready
module approx_add_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH:0]         add_o,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH:0]         rsp_sum,
  input  logic                   rsp_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_idx;
  logic            win_found;
  logic [2:0]      cnt;

  // (base + off) mod N_REQ for off in 0..N_REQ; avoids a divider for non-power-of-two N_REQ
  function automatic logic [ID_W-1:0] rr_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[ID_W-1:0];
  endfunction

  // Descending scan so the requester closest to rr_ptr overwrites the others.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_add(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_add(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (win_found && !rst) begin
          req_ready[win_idx] = 1'b1;
          state_nxt          = EXEC;
        end
      end
      EXEC:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      cnt       <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            add_a  <= req_a[win_idx*WIDTH +: WIDTH];
            add_b  <= req_b[win_idx*WIDTH +: WIDTH];
            rsp_id <= win_idx;
            rr_ptr <= rr_add(win_idx, 1);
            cnt    <= 3'(ADD_LAT - 1);
          end
        end
        EXEC: begin
          if (cnt == 3'd0) begin
            rsp_sum   <= add_o;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP:    if (rsp_ready) rsp_valid <= 1'b0;
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_approx_add_rr_sched.sv
// Directed bench for approx_add_rr_sched: one ADD_LAT=1 instance with a scoreboard monitor,
// plus an ADD_LAT=3 instance driving a two-cycle-delayed adder stub for settle timing.
module tb_approx_add_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [15:0] add_a, add_b;
  logic [16:0] add_o;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [16:0] rsp_sum;
  logic        rsp_ready;
  logic        busy;
  logic        use_approx;

  logic [3:0]  req_valid3;
  logic [63:0] req_a3, req_b3;
  logic [3:0]  req_ready3;
  logic [15:0] add_a3, add_b3;
  logic [16:0] add_o3;
  logic        rsp_valid3;
  logic [1:0]  rsp_id3;
  logic [16:0] rsp_sum3;
  logic        rsp_ready3 = 1'b1;
  logic        busy3;
  logic [16:0] d1 = '0, d2 = '0;

  int n_assert = 0;
  int n_fail   = 0;
  logic [1:0]  id_q[$];
  logic [16:0] sum_q[$];
  logic [16:0] sb3[$];
  int order[6] = '{0, 1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  // Lower-part-OR approximate adder: low nibble ORed, carry-in to the upper part from a[3]&b[3].
  function automatic logic [16:0] approx_sum(input logic [15:0] a, input logic [15:0] b);
    logic [12:0] hi;
    hi = {1'b0, a[15:4]} + {1'b0, b[15:4]} + {12'd0, a[3] & b[3]};
    return {hi, a[3:0] | b[3:0]};
  endfunction

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    return use_approx ? approx_sum(a, b) : ({1'b0, a} + {1'b0, b});
  endfunction

  assign add_o  = model(add_a, add_b);
  assign add_o3 = d2;
  always @(posedge clk) begin
    d1 <= {1'b0, add_a3} + {1'b0, add_b3};
    d2 <= d1;
  end

  approx_add_rr_sched #(.N_REQ(4), .WIDTH(16), .ADD_LAT(1), .ID_W(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  approx_add_rr_sched #(.N_REQ(4), .WIDTH(16), .ADD_LAT(3), .ID_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .add_a(add_a3), .add_b(add_b3), .add_o(add_o3),
    .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .rsp_ready(rsp_ready3),
    .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  // Scoreboard: push on every observed grant, pop and compare on every accepted response.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != 4'd0) begin
        check("grant_onehot", $countones(req_ready), 1);
        for (int i = 0; i < 4; i++) begin
          if (req_ready[i]) begin
            id_q.push_back(2'(i));
            sum_q.push_back(model(req_a[i*16 +: 16], req_b[i*16 +: 16]));
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", (id_q.size() != 0), 1);
        if (id_q.size() != 0) begin
          check("sb_id", rsp_id, id_q.pop_front());
          check("sb_sum", rsp_sum, sum_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    use_approx = 1'b0; req_valid3 = '0; req_a3 = '0; req_b3 = '0;
    tick(2);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_add_a", add_a, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_id", rsp_id, 0);

    // single op from requester 1
    req_valid = 4'b0010; set_op(1, 16'h0100, 16'h0100); rst = 1'b0; rsp_ready = 1'b1; #1;
    check("single_grant", req_ready, 4'b0010);
    tick(1); req_valid = 4'b0000;
    check("single_add_a", add_a, 16'h0100);
    check("single_add_b", add_b, 16'h0100);
    check("single_exec_ready", req_ready, 0);
    check("single_busy", busy, 1);
    tick(1);
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 1);
    check("single_rsp_sum", rsp_sum, 17'h00200);
    tick(1);
    check("single_done_valid", rsp_valid, 0);
    check("single_done_busy", busy, 0);

    // round-robin fairness with all requesters valid
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i));
    req_valid = 4'b1111; #1;
    for (int g = 0; g < 6; g++) begin
      check("rr_grant", req_ready, 4'b0001 << order[g]);
      tick(1);
      if (g == 5) req_valid = 4'b0000;
      check("rr_gap1", req_ready, 0);
      tick(1);
      check("rr_gap2", req_ready, 0);
      tick(1);
    end

    // backpressure: response held while requester 2 waits
    rsp_ready = 1'b0; set_op(0, 16'h7000, 16'h9001); req_valid = 4'b0001; #1;
    check("bp_grant0", req_ready, 4'b0001);
    tick(1); req_valid = 4'b0100; set_op(2, 16'h1234, 16'h4321); #1;
    check("bp_exec_ready", req_ready, 0);
    tick(1);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 0);
      check("bp_sum", rsp_sum, 17'h10001);
      check("bp_ready_low", req_ready, 0);
      tick(1);
    end
    rsp_ready = 1'b1; #1;
    check("bp_accept_ready", req_ready, 0);
    tick(1);
    check("bp_grant2", req_ready, 4'b0100);
    check("bp_valid_clear", rsp_valid, 0);
    tick(1); req_valid = 4'b0000;
    tick(2);

    // approximate pass-through, carry chain broken by the OR-ed low part
    use_approx = 1'b1; set_op(3, 16'hFFFF, 16'h0001); req_valid = 4'b1000; #1;
    check("apx_grant3", req_ready, 4'b1000);
    tick(1); req_valid = 4'b0000;
    tick(1);
    check("apx_valid", rsp_valid, 1);
    check("apx_sum", rsp_sum, 17'h0FFFF);
    tick(1); use_approx = 1'b0;

    // settle timing on the ADD_LAT=3 instance
    req_a3[15:0] = 16'h1234; req_b3[15:0] = 16'h1111; req_valid3 = 4'b0001; #1;
    check("settle_grant", req_ready3, 4'b0001);
    sb3.push_back(17'h02345);
    tick(1); req_valid3 = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      check("settle_wait", rsp_valid3, 0);
      tick(1);
    end
    check("settle_valid", rsp_valid3, 1);
    check("settle_sum", rsp_sum3, sb3.pop_front());
    tick(1);

    // reset during EXEC
    set_op(1, 16'h0AAA, 16'h0555); req_valid = 4'b0010; #1;
    check("rexec_grant1", req_ready, 4'b0010);
    tick(1); req_valid = 4'b0000; rst = 1'b1;
    tick(1); rst = 1'b0; id_q.delete(); sum_q.delete();
    check("rexec_valid", rsp_valid, 0);
    check("rexec_busy", busy, 0);
    req_valid = 4'b1111; #1;
    check("rexec_ptr0", req_ready, 4'b0001);
    tick(1); req_valid = 4'b0000;
    tick(2);

    // reset during RESP
    rsp_ready = 1'b0; req_valid = 4'b0010; #1;
    check("rresp_grant1", req_ready, 4'b0010);
    tick(1); req_valid = 4'b0000;
    tick(1);
    check("rresp_pending", rsp_valid, 1);
    rst = 1'b1;
    tick(1); rst = 1'b0; id_q.delete(); sum_q.delete();
    check("rresp_valid", rsp_valid, 0);
    check("rresp_busy", busy, 0);
    rsp_ready = 1'b1; req_valid = 4'b1111; #1;
    check("rresp_ptr0", req_ready, 4'b0001);
    tick(1); req_valid = 4'b0000;
    tick(3);
    check("sb_drained", id_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
